// File: rtl/clk_div_pkg.sv
// Shared constants for the divided-clock sampler: counter width, default
// division ratios and the elaboration-time legality check for COUNTER_DIV.
package clk_div_pkg;

  localparam int unsigned CNT_W              = 25;
  localparam int unsigned DIV_SIM            = 4;
  localparam int unsigned DIV_100HZ_AT_50MHZ = 250000;

  // A ratio is legal when it is non-zero and COUNTER_DIV-1 fits in CNT_W bits.
  function automatic bit div_legal(input int unsigned div);
    return (div >= 1) && (div <= (2 ** CNT_W) - 1);
  endfunction

endpackage

// File: rtl/clk_divider.sv
// Programmable square-wave divider: Clk_out toggles every COUNTER_DIV Clk edges,
// and rise_en flags the edge on which Clk_out will go 0->1.
module clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned COUNTER_DIV = DIV_SIM
) (
  input  logic Clk,
  input  logic Reset,
  output logic Clk_out,
  output logic rise_en
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(COUNTER_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    clk_out_d = clk_out_q;
    if (cnt_q == TERM) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  // Combinational so the sampler updates on the very edge Clk_out rises.
  assign rise_en = (cnt_q == TERM) && !clk_out_q;
  assign Clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_dff.sv
// Slow-rate D flip-flop: samples D once per divided-clock period, on the Clk edge
// where Clk_out rises. Everything stays in the Clk domain via an enable.
module clk_div_dff
  import clk_div_pkg::*;
#(
  parameter int unsigned COUNTER_DIV = DIV_SIM
) (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Clk_out,
  output logic Q,
  output logic Qn
);

  if (!div_legal(COUNTER_DIV)) begin : g_bad_div
    $error("clk_div_dff: COUNTER_DIV must be in 1..2^CNT_W-1");
  end

  logic rise_en;
  logic q_q, q_d;
  logic qn_q, qn_d;

  clk_divider #(
    .COUNTER_DIV(COUNTER_DIV)
  ) u_div (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clk_out (Clk_out),
    .rise_en (rise_en)
  );

  always_comb begin
    q_d  = q_q;
    qn_d = qn_q;
    if (rise_en) begin
      q_d  = D;
      qn_d = ~D;
    end
  end

  // Qn is its own register so neither output has logic after the flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q  <= 1'b0;
      qn_q <= 1'b1;
    end else begin
      q_q  <= q_d;
      qn_q <= qn_d;
    end
  end

  assign Q  = q_q;
  assign Qn = qn_q;

endmodule

// File: tb/tb_clk_div_dff.sv
// Randomized bench for clk_div_dff at three division ratios, compared every edge
// against an edge-count reference model.
module tb_clk_div_dff;

  localparam int NDUT = 3;
  localparam int DIV4 = 4;
  localparam int DIV1 = 1;
  localparam int DIV3 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_in = 1'b0;
  logic [NDUT-1:0] co_w, q_w, qn_w;

  int tests_run = 0;
  int tests_failed = 0;

  int div_m [NDUT];
  int k_m   [NDUT];
  logic q_m [NDUT];

  always #10 clk = ~clk;

  clk_div_dff #(.COUNTER_DIV(DIV4)) u_dut4 (
    .Clk(clk), .Reset(reset), .D(d_in), .Clk_out(co_w[0]), .Q(q_w[0]), .Qn(qn_w[0])
  );
  clk_div_dff #(.COUNTER_DIV(DIV1)) u_dut1 (
    .Clk(clk), .Reset(reset), .D(d_in), .Clk_out(co_w[1]), .Q(q_w[1]), .Qn(qn_w[1])
  );
  clk_div_dff #(.COUNTER_DIV(DIV3)) u_dut3 (
    .Clk(clk), .Reset(reset), .D(d_in), .Clk_out(co_w[2]), .Q(q_w[2]), .Qn(qn_w[2])
  );

  task automatic check_val(input string tag, input int idx, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s[div=%0d] t=%0t got=%b exp=%b", tag, div_m[idx], $time, got, exp);
    end
  endtask

  // Model: k counts non-reset edges since the last reset edge. Clk_out is the
  // parity of k/DIV, and D is captured whenever k lands on an odd multiple of DIV.
  task automatic model_edge(input logic r, input logic d);
    for (int i = 0; i < NDUT; i++) begin
      if (r) begin
        k_m[i] = 0;
        q_m[i] = 1'b0;
      end else begin
        k_m[i] = k_m[i] + 1;
        if (k_m[i] % (2 * div_m[i]) == div_m[i]) q_m[i] = d;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      check_val("clk_out", i, co_w[i], logic'((k_m[i] / div_m[i]) % 2));
      check_val("q", i, q_w[i], q_m[i]);
      check_val("qn", i, qn_w[i], ~q_m[i]);
    end
  endtask

  task automatic run_edge(input logic r, input logic d);
    @(negedge clk);
    reset = r;
    d_in  = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all();
    $display("[TB] t=%0t rst=%b d=%b co=%b q=%b qn=%b", $time, r, d, co_w, q_w, qn_w);
  endtask

  initial begin
    div_m[0] = DIV4;
    div_m[1] = DIV1;
    div_m[2] = DIV3;
    for (int i = 0; i < NDUT; i++) begin
      k_m[i] = 0;
      q_m[i] = 1'b0;
    end

    // First edge at 10 ns with Reset already high.
    @(posedge clk);
    model_edge(1'b1, 1'b0);
    #1;
    check_all();
    for (int i = 0; i < 4; i++) run_edge(1'b1, 1'(i & 1));

    // Long high D then a glitch between sample points, then random traffic.
    for (int i = 0; i < 20; i++) run_edge(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) run_edge(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) run_edge(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) run_edge(1'b0, 1'b0);

    for (int n = 0; n < 700; n++) begin
      logic r;
      logic d;
      r = ($urandom_range(0, 49) == 0);
      d = 1'($urandom_range(0, 1));
      run_edge(r, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
